// File: rtl/ext_load_ctrl_pkg.sv
// Shared constants for the external load sequencer.
//   BW / NW        : beat width and packed NIT entry width
//   NIT_BEATS      : beats consumed per NIT entry
//   NIT_TAIL_W     : bits of the last NIT beat that land in the entry
//   St*            : sequencer state encoding
package ext_load_ctrl_pkg;

  localparam int unsigned BW         = 128;
  localparam int unsigned NW         = 330;
  localparam int unsigned NIT_BEATS  = 3;
  localparam int unsigned NIT_TAIL_W = NW - 2 * BW;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StNit    = 3'd1;
  localparam logic [2:0] StInput  = 3'd2;
  localparam logic [2:0] StWeight = 3'd3;
  localparam logic [2:0] StFin    = 3'd4;

  // First phase (in load order) that still has work; FIN when none do.
  function automatic logic [2:0] first_phase(input logic nit_nz, input logic in_nz,
                                             input logic w_nz);
    if (nit_nz)     return StNit;
    else if (in_nz) return StInput;
    else if (w_nz)  return StWeight;
    else            return StFin;
  endfunction

endpackage

// File: rtl/ext_load_ctrl_nit_beat_packer.sv
// Assembles three accepted beats into one NIT entry.
//   clk, rstn      : clock, async active-low reset
//   accept_i       : a beat is accepted this cycle
//   data_i         : beat payload
//   last_beat_o    : combinational, this accept completes an entry
//   entry_valid_o  : one-cycle pulse, entry_o updated this cycle
//   entry_o        : packed entry, holds between pulses
module nit_beat_packer
  import ext_load_ctrl_pkg::*;
#(
  parameter int unsigned BeatW  = BW,
  parameter int unsigned EntryW = NW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              accept_i,
  input  logic [BeatW-1:0]  data_i,
  output logic              last_beat_o,
  output logic              entry_valid_o,
  output logic [EntryW-1:0] entry_o
);

  localparam int unsigned TailW = EntryW - 2 * BeatW;

  logic [1:0]        beat_q, beat_d;
  logic [BeatW-1:0]  lo_q, lo_d, mid_q, mid_d;
  logic [EntryW-1:0] entry_q, entry_d;
  logic              valid_q, valid_d;

  assign last_beat_o = accept_i && (beat_q == 2'(NIT_BEATS - 1));

  always_comb begin
    beat_d  = beat_q;
    lo_d    = lo_q;
    mid_d   = mid_q;
    entry_d = entry_q;
    valid_d = last_beat_o;
    if (accept_i) begin
      case (beat_q)
        2'd0: begin
          lo_d   = data_i;
          beat_d = 2'd1;
        end
        2'd1: begin
          mid_d  = data_i;
          beat_d = 2'd2;
        end
        default: begin
          // Upper bits of the final beat are padding and are dropped.
          entry_d = {data_i[TailW-1:0], mid_q, lo_q};
          beat_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_q  <= '0;
      lo_q    <= '0;
      mid_q   <= '0;
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      lo_q    <= lo_d;
      mid_q   <= mid_d;
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign entry_valid_o = valid_q;
  assign entry_o       = entry_q;

endmodule

// File: rtl/ext_load_ctrl.sv
// Host-side load sequencer: turns one valid/ready beat stream into NIT writes,
// then input-line writes, then weight-line writes, and pulses LOAD_DONE.
//   clk, rstn                 : clock, async active-low reset
//   start_load + N_* / INIT_* : job start and job description (sampled in IDLE)
//   s_valid/s_data/s_ready    : beat stream
//   NIT_addr_external, NIT_external_data, nit_we             : NIT write port
//   global_buf_write_external, waddr_external, GB_data_line  : global-buffer write port
//   LOAD_DONE, busy           : completion pulse, job in progress
module ext_load_ctrl
  import ext_load_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = 8,
  parameter int unsigned length                = 16,
  parameter int unsigned NIT_addr_width        = 12,
  parameter int unsigned NIT_neighbor          = 32,
  parameter int unsigned NIT_point_index       = 10,
  parameter int unsigned global_buf_addr_width = 17,
  localparam int unsigned BeatW  = DATA_WIDTH * length,
  localparam int unsigned EntryW = (NIT_neighbor + 1) * NIT_point_index
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start_load,
  input  logic [NIT_addr_width:0]          N_NIT,
  input  logic [global_buf_addr_width:0]   N_INPUT_LINES,
  input  logic [global_buf_addr_width:0]   N_WEIGHT_LINES,
  input  logic [global_buf_addr_width-1:0] INIT_INPUT_ADDR,
  input  logic [global_buf_addr_width-1:0] INIT_WEIGHT_ADDR,
  input  logic                             s_valid,
  input  logic [BeatW-1:0]                 s_data,
  output logic                             s_ready,
  output logic [NIT_addr_width-1:0]        NIT_addr_external,
  output logic [EntryW-1:0]                NIT_external_data,
  output logic                             nit_we,
  output logic                             global_buf_write_external,
  output logic [global_buf_addr_width-1:0] waddr_external,
  output logic [BeatW-1:0]                 GB_data_line,
  output logic                             LOAD_DONE,
  output logic                             busy
);

  localparam int unsigned AW = global_buf_addr_width;

  // Counters are one bit wider than the addresses so a full-size count terminates.
  logic [2:0]                state_q, state_d;
  logic [NIT_addr_width:0]   n_nit_q, n_nit_d, nit_cnt_q, nit_cnt_d;
  logic [AW:0]               n_in_q, n_in_d, n_w_q, n_w_d, line_cnt_q, line_cnt_d;
  logic [AW-1:0]             base_in_q, base_in_d, base_w_q, base_w_d;
  logic [NIT_addr_width-1:0] nit_addr_q, nit_addr_d;
  logic                      gb_we_q, gb_we_d, done_q, done_d;
  logic [AW-1:0]             waddr_q, waddr_d;
  logic [BeatW-1:0]          gb_data_q, gb_data_d;

  logic accept, nit_accept, nit_last;

  assign s_ready    = (state_q == StNit) || (state_q == StInput) || (state_q == StWeight);
  assign accept     = s_valid && s_ready;
  assign nit_accept = accept && (state_q == StNit);

  nit_beat_packer #(
    .BeatW (BeatW),
    .EntryW(EntryW)
  ) u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .accept_i     (nit_accept),
    .data_i       (s_data),
    .last_beat_o  (nit_last),
    .entry_valid_o(nit_we),
    .entry_o      (NIT_external_data)
  );

  always_comb begin
    state_d    = state_q;
    n_nit_d    = n_nit_q;
    n_in_d     = n_in_q;
    n_w_d      = n_w_q;
    base_in_d  = base_in_q;
    base_w_d   = base_w_q;
    nit_cnt_d  = nit_cnt_q;
    line_cnt_d = line_cnt_q;
    nit_addr_d = nit_addr_q;
    waddr_d    = waddr_q;
    gb_data_d  = gb_data_q;
    gb_we_d    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_load) begin
          n_nit_d    = N_NIT;
          n_in_d     = N_INPUT_LINES;
          n_w_d      = N_WEIGHT_LINES;
          base_in_d  = INIT_INPUT_ADDR;
          base_w_d   = INIT_WEIGHT_ADDR;
          nit_cnt_d  = '0;
          line_cnt_d = '0;
          state_d    = first_phase(N_NIT != '0, N_INPUT_LINES != '0, N_WEIGHT_LINES != '0);
        end
      end
      StNit: begin
        if (nit_last) begin
          nit_addr_d = nit_cnt_q[NIT_addr_width-1:0];
          nit_cnt_d  = nit_cnt_q + 1'b1;
          if (nit_cnt_d == n_nit_q) begin
            state_d = first_phase(1'b0, n_in_q != '0, n_w_q != '0);
          end
        end
      end
      StInput, StWeight: begin
        if (accept) begin
          gb_we_d    = 1'b1;
          gb_data_d  = s_data;
          // AW-bit sum wraps naturally at the top of the buffer.
          waddr_d    = ((state_q == StInput) ? base_in_q : base_w_q) + line_cnt_q[AW-1:0];
          line_cnt_d = line_cnt_q + 1'b1;
          if (state_q == StInput && line_cnt_d == n_in_q) begin
            line_cnt_d = '0;
            state_d    = first_phase(1'b0, 1'b0, n_w_q != '0);
          end else if (state_q == StWeight && line_cnt_d == n_w_q) begin
            line_cnt_d = '0;
            state_d    = StFin;
          end
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      n_nit_q    <= '0;
      n_in_q     <= '0;
      n_w_q      <= '0;
      base_in_q  <= '0;
      base_w_q   <= '0;
      nit_cnt_q  <= '0;
      line_cnt_q <= '0;
      nit_addr_q <= '0;
      waddr_q    <= '0;
      gb_data_q  <= '0;
      gb_we_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_nit_q    <= n_nit_d;
      n_in_q     <= n_in_d;
      n_w_q      <= n_w_d;
      base_in_q  <= base_in_d;
      base_w_q   <= base_w_d;
      nit_cnt_q  <= nit_cnt_d;
      line_cnt_q <= line_cnt_d;
      nit_addr_q <= nit_addr_d;
      waddr_q    <= waddr_d;
      gb_data_q  <= gb_data_d;
      gb_we_q    <= gb_we_d;
      done_q     <= done_d;
    end
  end

  assign NIT_addr_external         = nit_addr_q;
  assign global_buf_write_external = gb_we_q;
  assign waddr_external            = waddr_q;
  assign GB_data_line              = gb_data_q;
  assign LOAD_DONE                 = done_q;
  assign busy                      = (state_q != StIdle);

endmodule

// File: tb/tb_ext_load_ctrl.sv
module tb_ext_load_ctrl;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start_load;
  logic [12:0]  N_NIT;
  logic [17:0]  N_INPUT_LINES, N_WEIGHT_LINES;
  logic [16:0]  INIT_INPUT_ADDR, INIT_WEIGHT_ADDR;
  logic         s_valid;
  logic [127:0] s_data;
  logic         s_ready;
  logic [11:0]  NIT_addr_external;
  logic [329:0] NIT_external_data;
  logic         nit_we;
  logic         global_buf_write_external;
  logic [16:0]  waddr_external;
  logic [127:0] GB_data_line;
  logic         LOAD_DONE;
  logic         busy;

  int n_checks = 0;
  int n_err    = 0;

  ext_load_ctrl dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .start_load               (start_load),
    .N_NIT                    (N_NIT),
    .N_INPUT_LINES            (N_INPUT_LINES),
    .N_WEIGHT_LINES           (N_WEIGHT_LINES),
    .INIT_INPUT_ADDR          (INIT_INPUT_ADDR),
    .INIT_WEIGHT_ADDR         (INIT_WEIGHT_ADDR),
    .s_valid                  (s_valid),
    .s_data                   (s_data),
    .s_ready                  (s_ready),
    .NIT_addr_external        (NIT_addr_external),
    .NIT_external_data        (NIT_external_data),
    .nit_we                   (nit_we),
    .global_buf_write_external(global_buf_write_external),
    .waddr_external           (waddr_external),
    .GB_data_line             (GB_data_line),
    .LOAD_DONE                (LOAD_DONE),
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [329:0] obs, input logic [329:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [31:0] s);
    return {s * 32'h9E37_79B9, ~s, s + 32'h1234_5678, s ^ 32'hDEAD_BEEF};
  endfunction

  task automatic start_job(input int nn, input int ni, input int nw,
                           input logic [16:0] ai, input logic [16:0] aw);
    N_NIT            = 13'(nn);
    N_INPUT_LINES    = 18'(ni);
    N_WEIGHT_LINES   = 18'(nw);
    INIT_INPUT_ADDR  = ai;
    INIT_WEIGHT_ADDR = aw;
    start_load       = 1'b1;
    tick();
    start_load = 1'b0;
    // Scramble job inputs: the DUT must have latched them.
    N_NIT            = '1;
    N_INPUT_LINES    = '1;
    N_WEIGHT_LINES   = '1;
    INIT_INPUT_ADDR  = 17'h15555;
    INIT_WEIGHT_ADDR = 17'h0AAAA;
  endtask

  // Streams n_in input lines then n_w weight lines and checks every write and the done pulse.
  task automatic run_lines(input int n_in, input logic [16:0] a_in, input int n_w,
                           input logic [16:0] a_w, input bit gap, input int seed);
    logic [16:0]  ea;
    logic [127:0] ed;
    start_job(0, n_in, n_w, a_in, a_w);
    chk("ready_in_phase", s_ready, 1'b1);
    for (int i = 0; i < n_in + n_w; i++) begin
      ed      = mk(32'(seed + i));
      ea      = (i < n_in) ? a_in + 17'(i) : a_w + 17'(i - n_in);
      s_valid = 1'b1;
      s_data  = ed;
      tick();
      chk("gb_we", global_buf_write_external, 1'b1);
      chk("waddr", waddr_external, ea);
      chk("gb_data", GB_data_line, ed);
      if (gap && i != n_in + n_w - 1) begin
        s_valid = 1'b0;
        s_data  = mk(32'hFFFF);
        tick();
        chk("gb_we_gap", global_buf_write_external, 1'b0);
        chk("waddr_hold", waddr_external, ea);
        chk("gb_data_hold", GB_data_line, ed);
      end
    end
    s_valid = 1'b0;
    chk("done_early", LOAD_DONE, 1'b0);
    chk("ready_fin", s_ready, 1'b0);
    tick();
    chk("done_pulse", LOAD_DONE, 1'b1);
    chk("gb_we_after", global_buf_write_external, 1'b0);
    chk("idle_after", busy, 1'b0);
    tick();
    chk("done_once", LOAD_DONE, 1'b0);
  endtask

  initial begin
    logic [127:0] a0, a1, a2, b0, b1, b2;
    logic [329:0] ea_ent, eb_ent;

    rstn = 1'b0; start_load = 1'b0; s_valid = 1'b0; s_data = '0;
    N_NIT = '0; N_INPUT_LINES = '0; N_WEIGHT_LINES = '0;
    INIT_INPUT_ADDR = '0; INIT_WEIGHT_ADDR = '0;
    tick();
    tick();
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_nit_we", nit_we, 1'b0);
    chk("rst_gb_we", global_buf_write_external, 1'b0);
    chk("rst_done", LOAD_DONE, 1'b0);
    chk("rst_nit_data", NIT_external_data, '0);
    chk("rst_waddr", waddr_external, '0);
    #2 rstn = 1'b1;
    tick();

    // NIT-only job, with one s_valid gap inside entry A.
    a0 = mk(32'h100); a1 = mk(32'h101); a2 = mk(32'h102);
    b0 = mk(32'h200); b1 = mk(32'h201); b2 = mk(32'h202);
    ea_ent = {a2[73:0], a1, a0};
    eb_ent = {b2[73:0], b1, b0};
    start_job(2, 0, 0, 17'h0, 17'h0);
    chk("nit_ready", s_ready, 1'b1);
    chk("nit_busy", busy, 1'b1);
    s_valid = 1'b1; s_data = a0; tick();
    chk("nit_we_a0", nit_we, 1'b0);
    s_data = a1; tick();
    s_valid = 1'b0; s_data = mk(32'h999); tick();
    chk("nit_we_gap", nit_we, 1'b0);
    s_valid = 1'b1; s_data = a2; tick();
    chk("nit_we_a", nit_we, 1'b1);
    chk("nit_addr_a", NIT_addr_external, 12'd0);
    chk("nit_data_a", NIT_external_data, ea_ent);
    s_data = b0; tick();
    chk("nit_we_b0", nit_we, 1'b0);
    chk("nit_data_hold", NIT_external_data, ea_ent);
    s_data = b1; tick();
    s_data = b2; tick();
    s_valid = 1'b0;
    chk("nit_we_b", nit_we, 1'b1);
    chk("nit_addr_b", NIT_addr_external, 12'd1);
    chk("nit_data_b", NIT_external_data, eb_ent);
    chk("nit_fin_done", LOAD_DONE, 1'b0);
    tick();
    chk("nit_done", LOAD_DONE, 1'b1);
    chk("nit_we_off", nit_we, 1'b0);
    tick();
    chk("nit_done_once", LOAD_DONE, 1'b0);
    chk("nit_addr_hold", NIT_addr_external, 12'd1);

    // Input + weight, continuous and then gapped.
    run_lines(4, 17'h00000, 2, 17'h08000, 1'b0, 32'h300);
    run_lines(4, 17'h00000, 2, 17'h08000, 1'b1, 32'h300);

    // Address wrap.
    run_lines(4, 17'h1FFFE, 0, 17'h0, 1'b0, 32'h400);

    // All-zero job.
    start_job(0, 0, 0, 17'h0, 17'h0);
    chk("zero_ready_fin", s_ready, 1'b0);
    chk("zero_busy", busy, 1'b1);
    chk("zero_done_early", LOAD_DONE, 1'b0);
    tick();
    chk("zero_done", LOAD_DONE, 1'b1);
    chk("zero_ready", s_ready, 1'b0);
    chk("zero_gb_we", global_buf_write_external, 1'b0);
    chk("zero_nit_we", nit_we, 1'b0);
    tick();
    chk("zero_done_once", LOAD_DONE, 1'b0);

    // Mid-job reset after 3 of 8 lines; a start_load pulse while busy is ignored.
    start_job(0, 8, 0, 17'h00100, 17'h0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = mk(32'(32'h500 + i));
      if (i == 1) begin
        start_load      = 1'b1;
        N_INPUT_LINES   = 18'd1;
        INIT_INPUT_ADDR = 17'h00007;
      end
      tick();
      start_load = 1'b0;
      chk("abort_waddr", waddr_external, 17'h00100 + 17'(i));
      chk("abort_gb_we", global_buf_write_external, 1'b1);
    end
    chk("abort_busy", busy, 1'b1);
    s_data = mk(32'h503);
    #3 rstn = 1'b0;
    #1;
    chk("abort_rst_gb_we", global_buf_write_external, 1'b0);
    chk("abort_rst_waddr", waddr_external, '0);
    chk("abort_rst_data", GB_data_line, '0);
    chk("abort_rst_busy", busy, 1'b0);
    chk("abort_rst_ready", s_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", LOAD_DONE, 1'b0);
      chk("abort_no_we", global_buf_write_external, 1'b0);
    end
    s_valid = 1'b0;
    #2 rstn = 1'b1;
    tick();
    chk("post_rst_idle", busy, 1'b0);
    run_lines(3, 17'h00020, 1, 17'h00040, 1'b0, 32'h600);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ext_load_ctrl.md
Name: ext_load_ctrl

Overview:
- Host-side load sequencer sitting directly upstream of top.
- Accepts one 128-bit valid/ready beat stream and produces top's external load signals: NIT_addr_external, NIT_external_data, global_buf_write_external, waddr_external, GB_data_line and LOAD_DONE.
- Load order per job is fixed: NIT entries, then input lines, then weight lines. LOAD_DONE pulses when all three are written.

Parameters:
- DATA_WIDTH, 8, element width.
- length, 16, elements per global-buffer line; beat width BW = DATA_WIDTH*length = 128.
- NIT_addr_width, 12, NIT address width.
- NIT_neighbor, 32, neighbours per NIT entry.
- NIT_point_index, 10, point-index width; NIT entry width NW = (NIT_neighbor+1)*NIT_point_index = 330.
- global_buf_addr_width, 17, global-buffer address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start_load  in  1  one-cycle job start. Sampled only in IDLE.
- N_NIT  in  NIT_addr_width+1  NIT entries to load, 0..4096.
- N_INPUT_LINES  in  global_buf_addr_width+1  input lines to load.
- N_WEIGHT_LINES  in  global_buf_addr_width+1  weight lines to load.
- INIT_INPUT_ADDR  in  global_buf_addr_width  first input-line address.
- INIT_WEIGHT_ADDR  in  global_buf_addr_width  first weight-line address.
- s_valid  in  1  beat valid.
- s_data  in  BW  beat payload.
- s_ready  out  1  beat accepted when s_valid and s_ready are both high.
- NIT_addr_external  out  NIT_addr_width  NIT write address.
- NIT_external_data  out  NW  NIT entry.
- nit_we  out  1  one-cycle NIT write strobe.
- global_buf_write_external  out  1  global-buffer write strobe.
- waddr_external  out  global_buf_addr_width  global-buffer write address.
- GB_data_line  out  BW  global-buffer write data.
- LOAD_DONE  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. An asynchronous reset mid-job aborts the job immediately; no write strobe or LOAD_DONE follows.
- States: IDLE, NIT, INPUT, WEIGHT, FIN.
- Job start: in IDLE, start_load latches N_NIT, N_INPUT_LINES, N_WEIGHT_LINES, INIT_INPUT_ADDR and INIT_WEIGHT_ADDR. The next state is the first phase with a nonzero count. If all three counts are 0, the next state is FIN.
- start_load while busy is ignored.
- s_ready is 1 in NIT, INPUT and WEIGHT. It is combinational from state only and is 0 in IDLE and FIN. There is no downstream backpressure.
- NIT phase packing: 3 beats per entry.
  - Beat0 fills bits [127:0], beat1 fills [255:128], beat2 fills [329:256] from s_data[73:0]. s_data[127:74] of beat2 is discarded.
  - Beat counter 0..2 advances only on an accepted beat; s_valid gaps hold it.
  - When beat2 is accepted at cycle t: at t+1 NIT_external_data holds the packed entry, NIT_addr_external holds the entry index (0..N_NIT-1) and nit_we=1 for one cycle.
  - NIT_external_data and NIT_addr_external hold their values between writes.
- INPUT and WEIGHT phases: 1 beat per line.
  - A beat accepted at cycle t gives, at t+1, global_buf_write_external=1, GB_data_line=s_data and waddr_external = phase base + line index.
  - The address wraps modulo 2^global_buf_addr_width.
  - The strobe is 0 in any cycle after no accepted beat. waddr_external and GB_data_line hold their values.
- Phase transitions: the phase changes on acceptance of its final beat. The next state is the next nonzero phase, or FIN. The beat on the cycle after the transition already belongs to the new phase, so back-to-back streaming has no bubble.
- FIN: entered at cycle t+1 after the last beat was accepted at t (the final write strobe is at t+1). LOAD_DONE=1 at t+2 for exactly one cycle, then IDLE.
  - All-zero job: start at cycle s, FIN at s+1, LOAD_DONE at s+2.
- Counter widths: NIT and line counters are one bit wider than the address so a full 4096 / 2^17 count terminates correctly.

Decomposition:
- Shared package holds:
  - BW, NW, the beats-per-NIT constant (3) and the NIT tail width (74).
  - The state encoding (IDLE=0, NIT=1, INPUT=2, WEIGHT=3, FIN=4).
- One natural sub-module, nit_beat_packer: 3-beat to 330-bit assembler with an accept input, an entry_valid output and the packed entry.
- Sequencing and address generation stay in ext_load_ctrl.

Test Plan:
- Reset then load N_NIT=2, N_INPUT=0, N_WEIGHT=0 with beats A0..A2, B0..B2:
  - Two nit_we pulses.
  - Address 0 data = {A2[73:0],A1,A0}.
  - Address 1 data = {B2[73:0],B1,B0}.
  - LOAD_DONE two cycles after B2 is accepted.
- N_NIT=0, N_INPUT=4, INIT_INPUT_ADDR=0, N_WEIGHT=2, INIT_WEIGHT_ADDR=0x08000, continuous s_valid:
  - Writes to 0,1,2,3,0x08000,0x08001 on consecutive cycles.
  - Data matches beats; one LOAD_DONE.
- Same job with s_valid toggling 1,0,1,0: write strobes appear only after accepted beats, addresses stay contiguous, and the final result is identical.
- INIT_INPUT_ADDR=0x1FFFE, N_INPUT=4 -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- All counts 0 -> LOAD_DONE two cycles after start_load; no strobes; s_ready never 1.
- Reset asserted mid-INPUT after 3 of 8 lines -> outputs 0 immediately, no LOAD_DONE; start_load after release runs a full fresh job. start_load while busy has no effect.
